// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg: shared defaults, FSM state type and averaging depth for clock_period_meter
package clock_meter_pkg;
  localparam int DEF_WIDTH = 28;
  localparam int AVG_DEPTH = 4;
  typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: SYNC_STAGES-flop synchronizer plus delayed copy, giving one-cycle rise/fall strobes
// Ports: clk, rst (sync, active-high); d_i asynchronous input; rise_o/fall_o synchronized edge strobes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  // Bit SYNC_STAGES-1 is the synchronized level, bit SYNC_STAGES its one-cycle-delayed copy.
  logic [SYNC_STAGES:0] sync_q;
  always_ff @(posedge clk) begin
    sync_q <= rst ? '0 : {sync_q[SYNC_STAGES-1:0], d_i};
  end
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures rise-to-rise period and high time of an asynchronous square wave in clock_in cycles
// Ports: clock_in, reset (sync, active-high); sig_in asynchronous measured signal;
//        period/high_time last result; valid one-cycle update pulse; timeout level when no rise
//        arrives within 2^WIDTH-1 cycles; measuring high while not IDLE.
// Define PERIOD_METER_AVG_EN to publish the truncated average of every four measurements.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, hi_lat_q;
  logic             rise, fall;
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clock_in), .rst(reset), .d_i(sig_in), .rise_o(rise), .fall_o(fall)
  );
`ifdef PERIOD_METER_AVG_EN
  localparam int AW = WIDTH + 2;
  logic [AW-1:0] sum_p_q, sum_h_q, sum_p_d, sum_h_d;
  logic [1:0]    idx_q;
  always_comb begin
    sum_p_d = sum_p_q + AW'(cnt_q);
    sum_h_d = sum_h_q + AW'(hi_lat_q);
  end
`endif
  assign measuring = state_q == MEASURE;
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      sum_p_q   <= '0;
      sum_h_q   <= '0;
      idx_q     <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (state_q == IDLE) begin
        if (rise) begin
          state_q <= MEASURE;
          cnt_q   <= WIDTH'(1);
        end
      end else begin
        if (fall) hi_lat_q <= cnt_q;
        // A rise on the saturation cycle is still a measurement, so it is tested first.
        if (rise) begin
          cnt_q <= WIDTH'(1);
`ifdef PERIOD_METER_AVG_EN
          if (idx_q == 2'(AVG_DEPTH - 1)) begin
            period    <= WIDTH'(sum_p_d >> 2);
            high_time <= WIDTH'(sum_h_d >> 2);
            valid     <= 1'b1;
            timeout   <= 1'b0;
            sum_p_q   <= '0;
            sum_h_q   <= '0;
          end else begin
            sum_p_q <= sum_p_d;
            sum_h_q <= sum_h_d;
          end
          idx_q <= idx_q + 2'd1;
`else
          period    <= cnt_q;
          high_time <= hi_lat_q;
          valid     <= 1'b1;
          timeout   <= 1'b0;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_q <= IDLE;
          timeout <= 1'b1;
`ifdef PERIOD_METER_AVG_EN
          sum_p_q <= '0;
          sum_h_q <= '0;
          idx_q   <= '0;
`endif
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed and randomized self-checking bench for clock_period_meter
module tb_clock_period_meter;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int MAX = (1 << W) - 1;
`ifdef PERIOD_METER_AVG_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic valid, timeout, measuring;
  int checks = 0, errors = 0;
  int cyc = 0, n_valid = 0, last_valid_cyc = 0, rises = 0, lv_p = 0, lv_h = 0;
  int div = 10, hi = 5, ph = 0;
  bit gen_en = 0, last_sig = 0, prev_to = 0, chk_en = 0;
  int m_period = 0, m_high = 0, m_hilat = 0, t_rise = 0, tcyc = 0, acc_p = 0, acc_h = 0, acc_n = 0;
  bit m_valid = 0, m_timeout = 0, m_armed = 0, s_m, sd_m;
  bit hist[$];

  clock_period_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock_in(clk), .reset(rst), .sig_in(sig_in), .period(period), .high_time(high_time),
    .valid(valid), .timeout(timeout), .measuring(measuring)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: timestamps of the synchronized edges, delayed S samples as the synchronizer does.
  always @(posedge clk) begin
    tcyc++;
    if (rst) begin
      m_period = 0; m_high = 0; m_hilat = 0; m_valid = 0; m_timeout = 0; m_armed = 0;
      acc_p = 0; acc_h = 0; acc_n = 0;
      hist = {};
      repeat (S + 1) hist.push_front(1'b0);
    end else begin
      s_m = hist[S-1];
      sd_m = hist[S];
      m_valid = 0;
      if (m_armed) begin
        if (!s_m && sd_m) m_hilat = tcyc - t_rise;
        if (s_m && !sd_m) begin
          acc_p += tcyc - t_rise;
          acc_h += m_hilat;
          acc_n++;
          t_rise = tcyc;
          if (acc_n == DEPTH) begin
            m_period = acc_p / DEPTH; m_high = acc_h / DEPTH;
            m_valid = 1; m_timeout = 0;
            acc_p = 0; acc_h = 0; acc_n = 0;
          end
        end else if (tcyc - t_rise == MAX) begin
          m_timeout = 1; m_armed = 0;
          acc_p = 0; acc_h = 0; acc_n = 0;
        end
      end else if (s_m && !sd_m) begin
        m_armed = 1;
        t_rise = tcyc;
      end
      hist.push_front(sig_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("period", int'(period), m_period);
      chk("high_time", int'(high_time), m_high);
      chk("valid", int'(valid), int'(m_valid));
      chk("timeout", int'(timeout), int'(m_timeout));
      chk("measuring", int'(measuring), int'(m_armed));
    end
  end

  task automatic step();
    if (gen_en) begin
      sig_in = ph < hi;
      ph = (ph + 1 == div) ? 0 : ph + 1;
    end
    if (sig_in && !last_sig) rises++;
    last_sig = sig_in;
    prev_to = timeout;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (valid) begin
      n_valid++; last_valid_cyc = cyc; lv_p = int'(period); lv_h = int'(high_time);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    last_sig = 0;
    rises = 0;
  endtask

  task automatic wait_valid(input int n, input int bound);
    int target, k;
    target = n_valid + n;
    k = 0;
    while (n_valid < target && k < bound) begin
      step();
      k++;
    end
    chk("wait_valid", int'(n_valid >= target), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high"}, int'(high_time), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_measuring"}, int'(measuring), 0);
  endtask

  initial begin
    int c0, k;
    do_reset(3);
    chk_en = 1;
    chk_zero("reset");
    // divide 10 from a quiet input
    div = 10; hi = 5; ph = 0; gen_en = 1;
    wait_valid(1, 120);
    chk("div10_period", int'(period), 10);
    chk("div10_high", int'(high_time), 5);
    chk("model_period", m_period, 10);
    chk("model_high", m_high, 5);
`ifndef PERIOD_METER_AVG_EN
    chk("div10_rises_at_first_valid", rises, 2);
    c0 = cyc;
    wait_valid(1, 30);
    chk("div10_valid_spacing", cyc - c0, 10);
`endif
    div = 5; hi = 2; ph = 0;
    wait_valid(3, 150);
    chk("div5_period", int'(period), 5);
    chk("div5_high", int'(high_time), 2);
    div = 2; hi = 1; ph = 0;
    wait_valid(3, 60);
    chk("div2_period", int'(period), 2);
    chk("div2_high", int'(high_time), 1);
    // stuck low after activity
    gen_en = 0; sig_in = 0;
    k = 0;
    while (!timeout && k < 400) begin step(); k++; end
    chk("timeout_seen", int'(timeout), 1);
    chk("timeout_measuring", int'(measuring), 0);
    chk("timeout_period_held", int'(period), 2);
`ifndef PERIOD_METER_AVG_EN
    chk("timeout_delay", cyc - last_valid_cyc, 255);
`endif
    // restart at divide 6: timeout holds until the first valid
    rises = 0; div = 6; hi = 3; ph = 0; gen_en = 1;
    wait_valid(1, 80);
    chk("restart_period", int'(period), 6);
    chk("restart_high", int'(high_time), 3);
    chk("restart_timeout_before", int'(prev_to), 1);
    chk("restart_timeout_cleared", int'(timeout), 0);
`ifndef PERIOD_METER_AVG_EN
    chk("restart_rises", rises, 2);
`endif
    // reset in the middle of a divide-10 period
    div = 10; hi = 5; ph = 0;
    repeat (25) step();
    do_reset(1);
    chk_zero("midreset");
    wait_valid(1, 120);
    chk("midreset_period", int'(period), 10);
    chk("midreset_high", int'(high_time), 5);
`ifndef PERIOD_METER_AVG_EN
    chk("midreset_rises", rises, 2);
`endif
    // input already high when reset releases
    gen_en = 0; sig_in = 1;
    do_reset(1);
    repeat (4) step();
    div = 8; hi = 4; ph = 4; gen_en = 1;
    wait_valid(1, 100);
    chk("highrel_period", int'(period), 8);
    chk("highrel_high", int'(high_time), 4);
`ifdef PERIOD_METER_AVG_EN
    gen_en = 0; sig_in = 0;
    do_reset(1);
    c0 = n_valid;
    div = 10; hi = 5; ph = 0; gen_en = 1;
    repeat (20) step();
    div = 12; hi = 6; ph = 0;
    repeat (24) step();
    gen_en = 0; sig_in = 1;
    step();
    sig_in = 0;
    repeat (6) step();
    chk("avg_valid_count", n_valid - c0, 1);
    chk("avg_period", lv_p, 11);
    chk("avg_high", lv_h, 5);
`endif
    // randomized square waves with occasional resets
    for (int seg = 0; seg < 12; seg++) begin
      div = $urandom_range(2, 14);
      hi = $urandom_range(1, div - 1);
      ph = $urandom_range(0, div - 1);
      gen_en = 1;
      repeat ($urandom_range(20, 60)) step();
      if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
    end
    // stuck high after a rise
    gen_en = 0; sig_in = 0;
    repeat (3) step();
    sig_in = 1;
    repeat (300) step();
    chk("stuck_high_timeout", int'(timeout), 1);
    // random bit stream
    repeat (300) begin
      sig_in = 1'($urandom_range(0, 1));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of an external periodic signal, counted in `clock_in` cycles. It is the inverse of the clock divider: given a divided clock or any other square wave, it recovers the divide ratio and duty. It sits at the FPGA fabric edge, sampling asynchronous inputs. It also serves as the self-check monitor for divider outputs in the same clock domain.

## Interface
- `WIDTH`, default 28: counter and result width. Matches the divider's 28-bit divide ratio.
- `SYNC_STAGES`, default 2: number of input synchronizer flops. Must be at least 2.
- `clock_in`, input, 1: the single system clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `sig_in`, input, 1: measured signal. Asynchronous to `clock_in`.
- `period`, output, WIDTH: last measured rise-to-rise interval, in `clock_in` cycles.
- `high_time`, output, WIDTH: high duration within that same period.
- `valid`, output, 1: one-cycle pulse when `period` and `high_time` update.
- `timeout`, output, 1: level. Set when no rising edge arrives within 2^WIDTH-1 cycles.
- `measuring`, output, 1: high when the state is not IDLE.

## Operation
- **Input conditioning.** `sig_in` passes through SYNC_STAGES flops, then a delayed copy `s_d`.
  - Rise is defined as `s & ~s_d`.
  - Fall is defined as `~s & s_d`.
  - All synchronizer flops reset to 0.
- **States:**
  - **IDLE.** Waits for a rise. On a rise, go to MEASURE and set `cnt` to 1. No output update.
  - **MEASURE.** `cnt` increments every cycle.
    - On a fall: `hi_lat` takes `cnt`.
    - On a rise: `period` takes `cnt`, `high_time` takes `hi_lat`, `valid` pulses, `timeout` clears, and `cnt` returns to 1.
- **Timeout.** If `cnt` reaches 2^WIDTH-1 in MEASURE with no rise: `timeout` goes high and the state returns to IDLE.
  - `period` and `high_time` hold their last values.
  - This covers both stuck-high and stuck-low inputs.
- **Width rule.** `cnt` never wraps. The saturation value triggers the timeout.
- **Minimum measurable period is 2**, i.e. 1 cycle high and 1 cycle low. Input toggling faster than `clock_in`/2 is aliased and is not required to be correct.
- **Reset.** `period`, `high_time`, `valid`, `timeout`, `measuring`, `cnt` and `hi_lat` all go to 0, and the state goes to IDLE.
  - After a reset mid-measurement, the partial period is discarded.
  - The first `valid` after reset requires two detected rises.
- **Simultaneous events.** A rise in the same cycle `cnt` hits saturation counts as a rise, not a timeout.

## Timing
- **Latency.** A rising edge of `sig_in` sampled at cycle k gives `valid` at cycle k+SYNC_STAGES+1.
- **Accuracy.** Rise and fall see identical delay, so `period` is exact for signals synchronous to `clock_in`. Asynchronous inputs have ±1 cycle jitter.
- **Update rate.** `valid` fires at most once per measured period and is never asserted in consecutive cycles.
- **Timeout timing.** `timeout` asserts the cycle after `cnt` equals 2^WIDTH-1.

## Configuration
- **`PERIOD_METER_AVG_EN` defined:**
  - Four consecutive measurements are accumulated in WIDTH+2-bit sums.
  - `period` and `high_time` become each sum >>2, truncated.
  - `valid` pulses on every 4th rise only.
  - The accumulator and its 2-bit index clear on reset and on timeout.
- **Not defined:** each single period is published directly, as described in Operation.

## Structure
- **Package `clock_meter_pkg`:** default WIDTH (28), the state enum (IDLE, MEASURE), and the AVG_DEPTH constant (4).
- **Sub-module `sync_edge_detect`:** parameterized SYNC_STAGES synchronizer with rise and fall outputs. It is reused by the other asynchronous input blocks.
- **Top level:** the FSM, counters, latches and the optional averager.

## Test plan
- Driven by a divider with divide=10 on the same clock: `period`=10 and `high_time`=5 every 10 cycles. The first `valid` comes on the second detected rise.
- Divide=5: `period`=5, `high_time`=2. Divide=2: `period`=2, `high_time`=1.
- WIDTH=8 with `sig_in` held low after activity: `timeout`=1 exactly 255 cycles after the last rise, with no `valid`. Restart at divide=6: `timeout` clears on the first `valid`, which comes at the second rise, and `period`=6.
- Assert `reset` for 1 cycle mid-period at divide=10: all outputs are 0 the next cycle. No `valid` until two rises have occurred, then `period`=10.
- `sig_in` high at reset release: the rise only arms the FSM, and the first published `period` is a full period.
- With `PERIOD_METER_AVG_EN`, periods 10,10,12,12 with high times 5,5,6,6: a single `valid` with `period`=11 and `high_time`=5. No `valid` on rises 1–3.
